// File: rtl/awg_seg_player_if.sv
// Configuration, control and waveform-RAM read bus for one AWG playback channel.
//   master: configuration/control side (drives trig, stop, delayN/lenN/addrN, loop)
//   slave : awg_seg_player (drives rd_en, rd_addr, seg, busy, done)
// The loop input exists only when AWG_SEG_LOOP_EN is defined.
interface awg_seg_player_if #(
    parameter int unsigned AW = 24
) ();
    logic          trig;
    logic          stop;
    logic [AW-1:0] delay1, delay2, delay3;
    logic [AW-1:0] len1, len2, len3;
    logic [AW-1:0] addr1, addr2, addr3;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    seg;
    logic          busy;
    logic          done;
`ifdef AWG_SEG_LOOP_EN
    logic          loop;

    modport master (
        output trig, stop, delay1, delay2, delay3, len1, len2, len3, addr1, addr2, addr3, loop,
        input  rd_en, rd_addr, seg, busy, done
    );
    modport slave (
        input  trig, stop, delay1, delay2, delay3, len1, len2, len3, addr1, addr2, addr3, loop,
        output rd_en, rd_addr, seg, busy, done
    );
`else
    modport master (
        output trig, stop, delay1, delay2, delay3, len1, len2, len3, addr1, addr2, addr3,
        input  rd_en, rd_addr, seg, busy, done
    );
    modport slave (
        input  trig, stop, delay1, delay2, delay3, len1, len2, len3, addr1, addr2, addr3,
        output rd_en, rd_addr, seg, busy, done
    );
`endif
endinterface

// File: rtl/awg_seg_player.sv
// Per-channel AWG playback sequencer. On a trigger it latches three segment descriptors
// (delay, length, start address) and plays them in order: an idle delay, then a burst of
// sequential waveform-RAM read addresses. Zero-length segments are skipped with their delay.
// Ports:
//   I_clk  - system clock (configuration domain)
//   I_rst  - synchronous active-high reset
//   bus    - awg_seg_player_if.slave: trig/stop, nine config fields, rd_en/rd_addr,
//            seg (1..3 while busy, 0 idle), busy, done (one-cycle completion pulse)
// Optional: define AWG_SEG_LOOP_EN to add bus.loop; when high on the final sample of the
// last played segment the sequence restarts from segment 1 with freshly latched config.
module awg_seg_player #(
    parameter int unsigned AW   = 24,
    parameter int unsigned NSEG = 3
) (
    input  logic            I_clk,
    input  logic            I_rst,
    awg_seg_player_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StDly, StPlay, StFin} state_e;

    state_e        state_q;
    logic [1:0]    seg_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] rd_addr_q;
    logic          rd_en_q;
    logic          busy_q;
    logic          done_q;

    logic [AW-1:0] dly_q [NSEG];
    logic [AW-1:0] len_q [NSEG];
    logic [AW-1:0] adr_q [NSEG];

    logic [AW-1:0] in_dly [NSEG];
    logic [AW-1:0] in_len [NSEG];
    logic [AW-1:0] in_adr [NSEG];

    assign in_dly[0] = bus.delay1;
    assign in_dly[1] = bus.delay2;
    assign in_dly[2] = bus.delay3;
    assign in_len[0] = bus.len1;
    assign in_len[1] = bus.len2;
    assign in_len[2] = bus.len3;
    assign in_adr[0] = bus.addr1;
    assign in_adr[1] = bus.addr2;
    assign in_adr[2] = bus.addr3;

    // First segment numbered >= from with a nonzero length; 0 when none is left.
    function automatic logic [1:0] pick(input logic [2:0] from, input logic [2:0] nz);
        if (from <= 3'd1 && nz[0]) return 2'd1;
        if (from <= 3'd2 && nz[1]) return 2'd2;
        if (from <= 3'd3 && nz[2]) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [1:0] idx(input logic [1:0] s);
        return (s == 2'd0) ? 2'd0 : s - 2'd1;
    endfunction

    logic          last_smp;  // the current cycle issues the final sample of a segment
    logic          restart;
    logic          use_in;    // segment selection reads the live inputs, not the shadow
    logic          enter;     // a new segment (or FIN) is chosen this cycle
    logic [1:0]    first_seg;
    logic [1:0]    next_seg;
    logic [1:0]    go_seg;
    logic [AW-1:0] go_dly;
    logic [AW-1:0] go_len;
    logic [AW-1:0] go_adr;
    logic [2:0]    in_nz;
    logic [2:0]    sh_nz;

    always_comb begin
        in_nz     = {in_len[2] != '0, in_len[1] != '0, in_len[0] != '0};
        sh_nz     = {len_q[2] != '0, len_q[1] != '0, len_q[0] != '0};
        last_smp  = (state_q == StPlay) && (cnt_q == AW'(1));
        first_seg = pick(3'd1, in_nz);
        next_seg  = pick({1'b0, seg_q} + 3'd1, sh_nz);
`ifdef AWG_SEG_LOOP_EN
        restart   = last_smp && bus.loop && (next_seg == 2'd0);
`else
        restart   = 1'b0;
`endif
        use_in    = (state_q == StIdle) || restart;
        enter     = ((state_q == StIdle) && bus.trig) || last_smp;
        go_seg    = use_in ? first_seg : next_seg;
        go_dly    = use_in ? in_dly[idx(go_seg)] : dly_q[idx(go_seg)];
        go_len    = use_in ? in_len[idx(go_seg)] : len_q[idx(go_seg)];
        go_adr    = use_in ? in_adr[idx(go_seg)] : adr_q[idx(go_seg)];
    end

    always_ff @(posedge I_clk) begin
        if (I_rst || bus.stop) begin
            state_q   <= StIdle;
            seg_q     <= 2'd0;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int k = 0; k < int'(NSEG); k++) begin
                dly_q[k] <= '0;
                len_q[k] <= '0;
                adr_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (enter) begin
                if (use_in) begin
                    for (int k = 0; k < int'(NSEG); k++) begin
                        dly_q[k] <= in_dly[k];
                        len_q[k] <= in_len[k];
                        adr_q[k] <= in_adr[k];
                    end
                end
                if (go_seg == 2'd0) begin
                    state_q <= StFin;
                    seg_q   <= 2'd0;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    seg_q  <= go_seg;
                    busy_q <= 1'b1;
                    if (go_dly != '0) begin
                        state_q <= StDly;
                        cnt_q   <= go_dly;
                        rd_en_q <= 1'b0;
                    end else begin
                        state_q   <= StPlay;
                        cnt_q     <= go_len;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= go_adr;
                    end
                end
            end else begin
                unique case (state_q)
                    StDly: begin
                        if (cnt_q == AW'(1)) begin
                            state_q   <= StPlay;
                            cnt_q     <= len_q[idx(seg_q)];
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= adr_q[idx(seg_q)];
                        end else begin
                            cnt_q <= cnt_q - AW'(1);
                        end
                    end
                    // Final sample is handled by the enter path above.
                    StPlay: begin
                        cnt_q     <= cnt_q - AW'(1);
                        rd_addr_q <= rd_addr_q + AW'(1);
                    end
                    StFin:   state_q <= StIdle;
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.seg     = seg_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_awg_seg_player.sv
// Self-checking bench for awg_seg_player: a table of hand-computed run summaries, a
// cycle-by-cycle reference trace built from the segment rules, randomized runs with
// config churn and ignored retriggers, plus abort/reset and stop-vs-trigger sequences.
module tb_awg_seg_player;
    localparam int unsigned AW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    awg_seg_player_if #(.AW(AW)) bus ();
    awg_seg_player #(.AW(AW), .NSEG(3)) dut (.I_clk(clk), .I_rst(rst), .bus(bus));

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic [1:0]    seg;
        logic          busy;
        logic          done;
    } obs_t;

    typedef struct {
        logic [AW-1:0] d1, d2, d3, l1, l2, l3, a1, a2, a3;
        int            first_en;
        int            n_en;
        logic [AW-1:0] last_addr;
        int            done_off;
        int            busy_n;
    } vec_t;

    obs_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int st_first, st_n, st_done, st_busy;
    logic [AW-1:0] st_last;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    function automatic obs_t read_obs();
        obs_t o;
        o.en   = bus.rd_en;
        o.addr = bus.rd_addr;
        o.seg  = bus.seg;
        o.busy = bus.busy;
        o.done = bus.done;
        return o;
    endfunction

    task automatic set_cfg(input logic [AW-1:0] d1, d2, d3, l1, l2, l3, a1, a2, a3);
        bus.delay1 = d1; bus.delay2 = d2; bus.delay3 = d3;
        bus.len1   = l1; bus.len2   = l2; bus.len3   = l3;
        bus.addr1  = a1; bus.addr2  = a2; bus.addr3  = a3;
    endtask

    task automatic rand_cfg();
        logic [AW-1:0] d[3], l[3], a[3];
        for (int k = 0; k < 3; k++) begin
            d[k] = AW'($urandom_range(0, 4));
            l[k] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 6));
            a[k] = ($urandom_range(0, 3) == 0) ? AW'(24'hFFFFFF - $urandom_range(0, 4))
                                               : AW'($urandom);
        end
        set_cfg(d[0], d[1], d[2], l[0], l[1], l[2], a[0], a[1], a[2]);
    endtask

    // Expected outputs for cycles t+1.. after a trigger at t: per played segment D idle
    // cycles then LEN sequential addresses, followed by a single done cycle.
    function automatic void build_model();
        logic [AW-1:0] d[3], l[3], a[3];
        d[0] = bus.delay1; d[1] = bus.delay2; d[2] = bus.delay3;
        l[0] = bus.len1;   l[1] = bus.len2;   l[2] = bus.len3;
        a[0] = bus.addr1;  a[1] = bus.addr2;  a[2] = bus.addr3;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            if (l[k] != '0) begin
                for (int j = 0; j < int'(d[k]); j++)
                    exp_q.push_back('{en: 1'b0, addr: '0, seg: 2'(k + 1), busy: 1'b1, done: 1'b0});
                for (int j = 0; j < int'(l[k]); j++)
                    exp_q.push_back('{en: 1'b1, addr: AW'(a[k] + AW'(j)), seg: 2'(k + 1),
                                      busy: 1'b1, done: 1'b0});
            end
        end
        exp_q.push_back('{en: 1'b0, addr: '0, seg: 2'd0, busy: 1'b0, done: 1'b1});
    endfunction

    // mode 0: quiet; 1: random config churn and busy retriggers; 2: L1<=9 at t+2, trig at t+5
    task automatic check_run(input int mode);
        obs_t o, w;
        build_model();
        st_first = -1; st_n = 0; st_done = -1; st_busy = 0; st_last = '0;
        bus.trig = 1'b1;
        @(posedge clk); #1;
        bus.trig = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            o = read_obs();
            w = exp_q[i];
            if (o.en) begin
                if (st_first < 0) st_first = i + 1;
                st_n++;
                st_last = o.addr;
            end
            if (o.done && st_done < 0) st_done = i + 1;
            if (o.busy) st_busy++;
            if (!w.en) o.addr = '0;
            chk("trace", 64'(o), 64'(w));
            if (mode == 1) begin
                if ($urandom_range(0, 3) == 0) rand_cfg();
                if (i < exp_q.size() - 1 && $urandom_range(0, 4) == 0) bus.trig = 1'b1;
            end else if (mode == 2) begin
                if (i == 1) bus.len1 = AW'(9);
                if (i == 4) bus.trig = 1'b1;
            end
            @(posedge clk); #1;
            bus.trig = 1'b0;
        end
        o = read_obs();
        o.addr = '0;
        chk("post_idle", 64'(o), 64'(0));
    endtask

    task automatic abort_run(input bit use_rst);
        int viol;
        set_cfg(3, 0, 2, 4, 2, 1, 24'h100, 24'h200, 24'h300);
        bus.trig = 1'b1;
        @(posedge clk); #1;
        bus.trig = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        if (use_rst) rst = 1'b1; else bus.stop = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.stop = 1'b0;
        chk(use_rst ? "rst_zero" : "stop_zero", 64'(read_obs()), 64'(0));
        viol = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.rd_en || bus.busy || bus.done) viol++;
        end
        chk(use_rst ? "rst_quiet" : "stop_quiet", 64'(viol), 64'(0));
        check_run(0);
        chk("replay_done", 64'(st_done), 64'(13));
    endtask

    vec_t vecs[6];

    initial begin
        int viol;
        vecs[0] = '{3, 0, 2, 4, 2, 1, 24'h100, 24'h200, 24'h300, 4, 7, 24'h300, 13, 12};
        vecs[1] = '{5, 1, 7, 0, 3, 0, 24'h123, 24'hFFFFFE, 24'h456, 2, 3, 24'h000000, 5, 4};
        vecs[2] = '{1, 2, 3, 0, 0, 0, 24'h1, 24'h2, 24'h3, -1, 0, 24'h0, 1, 0};
        vecs[3] = '{9, 4, 0, 0, 0, 5, 24'h0, 24'h0, 24'h10, 1, 5, 24'h14, 6, 5};
        vecs[4] = '{0, 0, 0, 1, 0, 0, 24'hFFFFFF, 24'h0, 24'h0, 1, 1, 24'hFFFFFF, 2, 1};
        vecs[5] = '{2, 0, 3, 2, 0, 2, 24'h40, 24'h55, 24'h80, 3, 4, 24'h81, 10, 9};

        rst = 1'b1;
        bus.trig = 1'b0;
        bus.stop = 1'b0;
`ifdef AWG_SEG_LOOP_EN
        bus.loop = 1'b0;
`endif
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'(read_obs()), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            set_cfg(vecs[v].d1, vecs[v].d2, vecs[v].d3, vecs[v].l1, vecs[v].l2, vecs[v].l3,
                    vecs[v].a1, vecs[v].a2, vecs[v].a3);
            repeat (2) begin @(posedge clk); #1; end
            check_run(0);
            chk("first_en", 64'(st_first), 64'(vecs[v].first_en));
            chk("n_en", 64'(st_n), 64'(vecs[v].n_en));
            chk("last_addr", 64'(st_last), 64'(vecs[v].last_addr));
            chk("done_off", 64'(st_done), 64'(vecs[v].done_off));
            chk("busy_n", 64'(st_busy), 64'(vecs[v].busy_n));
        end

        // Config change and ignored retrigger mid-run: identical to the plain basic run.
        set_cfg(3, 0, 2, 4, 2, 1, 24'h100, 24'h200, 24'h300);
        check_run(2);
        chk("retrig_n_en", 64'(st_n), 64'(7));
        chk("retrig_done", 64'(st_done), 64'(13));

        abort_run(1'b0);
        abort_run(1'b1);

        // Stop wins over a simultaneous trigger in IDLE.
        set_cfg(3, 0, 2, 4, 2, 1, 24'h100, 24'h200, 24'h300);
        bus.stop = 1'b1;
        bus.trig = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        bus.trig = 1'b0;
        viol = 0;
        repeat (6) begin
            if (bus.rd_en || bus.busy || bus.done || bus.seg != 2'd0) viol++;
            @(posedge clk); #1;
        end
        chk("stop_trig_idle", 64'(viol), 64'(0));

        for (int r = 0; r < 40; r++) begin
            rand_cfg();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            check_run(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
